// File: rtl/queue_arbiter.sv
// Round-robin arbiter sharing an 8-entry byte queue between producers A/B and one consumer.
// Optional occupancy cross-check against q_len_in is enabled by defining QARB_LEN_CHECK_EN.
`timescale 1ns/1ps
module queue_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock10mhz,
  input  logic             reset,
  input  logic             a_valid_in,
  input  logic [WIDTH-1:0] a_data_in,
  output logic             a_ready_out,
  input  logic             b_valid_in,
  input  logic [WIDTH-1:0] b_data_in,
  output logic             b_ready_out,
  input  logic             pop_valid_in,
  output logic             pop_ready_out,
  output logic             rd_valid_out,
  output logic [WIDTH-1:0] rd_data_out,
  input  logic             flush_in,
  output logic             busy_out,
  output logic             q_enqueue_out,
  output logic             q_dequeue_out,
  output logic [WIDTH-1:0] q_data_out,
  input  logic [WIDTH-1:0] q_data_in,
  input  logic [LEN_W-1:0] q_len_in
`ifdef QARB_LEN_CHECK_EN
  ,
  output logic             len_err_out
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_POP} src_t;

  state_t           state_reg, state_next;
  src_t             last_reg, last_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic             elig_a, elig_b, elig_p, grant_en;
  logic             gnt_a, gnt_b, gnt_p;
  logic             flush_deq_next;
  logic             pop_pend_reg;

  assign elig_a   = a_valid_in && (count_reg < LEN_W'(DEPTH));
  assign elig_b   = b_valid_in && (count_reg < LEN_W'(DEPTH));
  assign elig_p   = pop_valid_in && (count_reg != '0);
  // Readys are gated by reset so they read 0 while reset is held, like the registered outputs.
  assign grant_en = reset && (state_reg == RUN) && !flush_in;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    gnt_p = 1'b0;
    if (grant_en) begin
      case (last_reg)
        SRC_A: begin
          if (elig_b) gnt_b = 1'b1;
          else if (elig_p) gnt_p = 1'b1;
          else if (elig_a) gnt_a = 1'b1;
        end
        SRC_B: begin
          if (elig_p) gnt_p = 1'b1;
          else if (elig_a) gnt_a = 1'b1;
          else if (elig_b) gnt_b = 1'b1;
        end
        default: begin
          if (elig_a) gnt_a = 1'b1;
          else if (elig_b) gnt_b = 1'b1;
          else if (elig_p) gnt_p = 1'b1;
        end
      endcase
    end
  end

  assign a_ready_out   = gnt_a;
  assign b_ready_out   = gnt_b;
  assign pop_ready_out = gnt_p;
  assign busy_out      = (state_reg == FLUSH);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    last_next  = last_reg;
    if (gnt_a) last_next = SRC_A;
    else if (gnt_b) last_next = SRC_B;
    else if (gnt_p) last_next = SRC_POP;
    case (state_reg)
      RUN: begin
        if (flush_in) state_next = FLUSH;
        if (gnt_a || gnt_b) count_next = count_reg + 1'b1;
        else if (gnt_p) count_next = count_reg - 1'b1;
      end
      FLUSH: begin
        if (count_reg == '0) state_next = RUN;
        else count_next = count_reg - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // One flush dequeue per FLUSH cycle that starts with entries left.
  assign flush_deq_next = (state_next == FLUSH) && (count_next != '0);

  always_ff @(posedge clock10mhz or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      last_reg      <= SRC_POP;
      count_reg     <= '0;
      q_enqueue_out <= 1'b0;
      q_dequeue_out <= 1'b0;
      q_data_out    <= '0;
      pop_pend_reg  <= 1'b0;
      rd_valid_out  <= 1'b0;
      rd_data_out   <= '0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      count_reg     <= count_next;
      q_enqueue_out <= gnt_a || gnt_b;
      if (gnt_a) q_data_out <= a_data_in;
      else if (gnt_b) q_data_out <= b_data_in;
      q_dequeue_out <= gnt_p || flush_deq_next;
      pop_pend_reg  <= gnt_p;
      rd_valid_out  <= pop_pend_reg;
      if (pop_pend_reg) rd_data_out <= q_data_in;
    end
  end

`ifdef QARB_LEN_CHECK_EN
  logic pulse_prev_reg;

  // Compare only when neither this nor the previous cycle had a strobe, so queue latency is settled.
  always_ff @(posedge clock10mhz or negedge reset) begin
    if (!reset) begin
      pulse_prev_reg <= 1'b0;
      len_err_out    <= 1'b0;
    end else begin
      pulse_prev_reg <= q_enqueue_out || q_dequeue_out;
      if (!q_enqueue_out && !q_dequeue_out && !pulse_prev_reg && (q_len_in != count_reg))
        len_err_out <= 1'b1;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^q_len_in;
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: vector table, hand-written corner sequences and a random run
// against a cycle-scheduled reference model that also stands in for the LIFO queue.
`timescale 1ns/1ps
module tb_queue_arbiter;
  localparam int DEPTH = 8;

  logic       clock10mhz = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid_in = 1'b0, b_valid_in = 1'b0, pop_valid_in = 1'b0, flush_in = 1'b0;
  logic [7:0] a_data_in = 8'h00, b_data_in = 8'h00, q_data_in = 8'h00;
  logic [3:0] q_len_in = 4'h0;
  logic       a_ready_out, b_ready_out, pop_ready_out, rd_valid_out, busy_out;
  logic       q_enqueue_out, q_dequeue_out;
  logic [7:0] rd_data_out, q_data_out;
`ifdef QARB_LEN_CHECK_EN
  logic       len_err_out;
`endif

  queue_arbiter dut (
    .clock10mhz(clock10mhz), .reset(reset),
    .a_valid_in(a_valid_in), .a_data_in(a_data_in), .a_ready_out(a_ready_out),
    .b_valid_in(b_valid_in), .b_data_in(b_data_in), .b_ready_out(b_ready_out),
    .pop_valid_in(pop_valid_in), .pop_ready_out(pop_ready_out),
    .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .flush_in(flush_in), .busy_out(busy_out),
    .q_enqueue_out(q_enqueue_out), .q_dequeue_out(q_dequeue_out), .q_data_out(q_data_out),
    .q_data_in(q_data_in), .q_len_in(q_len_in)
`ifdef QARB_LEN_CHECK_EN
    , .len_err_out(len_err_out)
`endif
  );

  always #50 clock10mhz = ~clock10mhz;

  // Reference model: occupancy, round-robin pointer, flush flag, and events keyed by cycle number.
  int         cyc = 0;
  int         m_count, m_last, len_bias = 0;
  bit         m_flush;
  logic [7:0] m_qdata;
  logic [7:0] stack[$];
  logic [7:0] enq_at[int];
  logic [7:0] rd_at[int];
  bit         popdeq_at[int];
  int         n_chk = 0, n_fail = 0;

  typedef struct {
    bit a_v; logic [7:0] a_d; bit b_v; logic [7:0] b_d; bit p_v; bit fl;
    bit e_ar; bit e_br; bit e_pr; bit e_enq; bit e_deq; bit e_rdv;
    logic [7:0] e_rdd; logic [7:0] e_qd;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(bit av, logic [7:0] ad, bit bv, logic [7:0] bd, bit pv, bit fl,
                              bit ar, bit br, bit pr, bit enq, bit deq, bit rdv,
                              logic [7:0] rdd, logic [7:0] qd);
    vec_t v;
    v.a_v = av; v.a_d = ad; v.b_v = bv; v.b_d = bd; v.p_v = pv; v.fl = fl;
    v.e_ar = ar; v.e_br = br; v.e_pr = pr; v.e_enq = enq; v.e_deq = deq; v.e_rdv = rdv;
    v.e_rdd = rdd; v.e_qd = qd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Index 0=A, 1=B, 2=POP; search starts just after the last granted source.
  function automatic int model_grant();
    bit elig[3];
    if (!reset || m_flush || flush_in) return -1;
    elig[0] = a_valid_in && (m_count < DEPTH);
    elig[1] = b_valid_in && (m_count < DEPTH);
    elig[2] = pop_valid_in && (m_count > 0);
    for (int k = 1; k <= 3; k++) begin
      int idx = (m_last + k) % 3;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input int ti = -1);
    int g;
    bit exp_deq;
    logic [7:0] top;
    top       = (stack.size() > 0) ? stack[stack.size()-1] : 8'h00;
    q_data_in = top;
    q_len_in  = 4'(stack.size() + len_bias);
    #1;
    g = model_grant();
    chk("a_ready", a_ready_out, g == 0);
    chk("b_ready", b_ready_out, g == 1);
    chk("pop_ready", pop_ready_out, g == 2);
    chk("busy", busy_out, m_flush);
    chk("q_enqueue", q_enqueue_out, enq_at.exists(cyc));
    if (enq_at.exists(cyc)) m_qdata = enq_at[cyc];
    chk("q_data", q_data_out, m_qdata);
    exp_deq = popdeq_at.exists(cyc) || (m_flush && m_count > 0);
    chk("q_dequeue", q_dequeue_out, exp_deq);
    chk("rd_valid", rd_valid_out, rd_at.exists(cyc));
    if (rd_at.exists(cyc)) chk("rd_data", rd_data_out, rd_at[cyc]);
    if (ti >= 0) begin
      chk($sformatf("vec%0d_a_ready", ti), a_ready_out, tbl[ti].e_ar);
      chk($sformatf("vec%0d_b_ready", ti), b_ready_out, tbl[ti].e_br);
      chk($sformatf("vec%0d_pop_ready", ti), pop_ready_out, tbl[ti].e_pr);
      chk($sformatf("vec%0d_q_enqueue", ti), q_enqueue_out, tbl[ti].e_enq);
      chk($sformatf("vec%0d_q_dequeue", ti), q_dequeue_out, tbl[ti].e_deq);
      chk($sformatf("vec%0d_q_data", ti), q_data_out, tbl[ti].e_qd);
      chk($sformatf("vec%0d_rd_valid", ti), rd_valid_out, tbl[ti].e_rdv);
      if (tbl[ti].e_rdv) chk($sformatf("vec%0d_rd_data", ti), rd_data_out, tbl[ti].e_rdd);
    end
    if (exp_deq) begin
      if (popdeq_at.exists(cyc)) rd_at[cyc+1] = top;
      if (stack.size() > 0) void'(stack.pop_back());
    end
    if (enq_at.exists(cyc)) stack.push_back(enq_at[cyc]);
    case (g)
      0: begin enq_at[cyc+1] = a_data_in; m_count++; m_last = 0; end
      1: begin enq_at[cyc+1] = b_data_in; m_count++; m_last = 1; end
      2: begin popdeq_at[cyc+1] = 1'b1; m_count--; m_last = 2; end
      default: ;
    endcase
    if (m_flush) begin
      if (m_count > 0) m_count--;
      else m_flush = 1'b0;
    end else if (flush_in && reset) begin
      m_flush = 1'b1;
    end
    @(posedge clock10mhz);
    cyc++;
    @(negedge clock10mhz);
  endtask

  task automatic idle_inputs();
    a_valid_in = 0; b_valid_in = 0; pop_valid_in = 0; flush_in = 0;
  endtask

  // Asserts reset mid-cycle, checks every output is already 0, then releases at a falling edge.
  task automatic do_reset(input string tag);
    logic [31:0] outs;
    #5 reset = 1'b0;
    #1;
    outs = {a_ready_out, b_ready_out, pop_ready_out, rd_valid_out, rd_data_out, busy_out,
            q_enqueue_out, q_dequeue_out, q_data_out};
`ifdef QARB_LEN_CHECK_EN
    outs = outs | 32'(len_err_out);
`endif
    chk({tag, "_outputs_zero"}, outs, 32'h0);
    $display("reset %s: outputs %0h", tag, outs);
    idle_inputs();
    m_count = 0; m_last = 2; m_flush = 0; m_qdata = 8'h00; len_bias = 0;
    stack.delete(); enq_at.delete(); rd_at.delete(); popdeq_at.delete();
    @(negedge clock10mhz);
    reset = 1'b1;
  endtask

  initial begin
    int nb, nd, nr;
    tbl[0]  = mk(1, 8'h11, 1, 8'h99, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(1, 8'h99, 1, 8'h22, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h11);
    tbl[2]  = mk(1, 8'h33, 1, 8'h99, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h22);
    tbl[3]  = mk(1, 8'h99, 1, 8'h44, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h33);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h44);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h44);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h44);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 8'h44, 8'h44);
    tbl[8]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 8'h33, 8'h44);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 8'h22, 8'h44);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 8'h11, 8'h44);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h44);

    do_reset("initial");

    for (int i = 0; i < 12; i++) begin
      a_valid_in = tbl[i].a_v; a_data_in = tbl[i].a_d;
      b_valid_in = tbl[i].b_v; b_data_in = tbl[i].b_d;
      pop_valid_in = tbl[i].p_v; flush_in = tbl[i].fl;
      step(i);
      $display("vec %0d: ready a/b/pop=%b%b%b enq=%b deq=%b rd=%b/%0h", i,
               tbl[i].e_ar, tbl[i].e_br, tbl[i].e_pr, tbl[i].e_enq, tbl[i].e_deq,
               tbl[i].e_rdv, tbl[i].e_rdd);
    end
    idle_inputs();

    // Fill to DEPTH with A, then a pop wins, then A is served again.
    do_reset("fill");
    a_valid_in = 1;
    for (int i = 0; i < DEPTH; i++) begin a_data_in = 8'(8'hA0 + i); step(); end
    #1 chk("full_a_blocked", a_ready_out, 1'b0);
    step();
    pop_valid_in = 1;
    #1 chk("full_pop_granted", pop_ready_out, 1'b1);
    chk("full_a_still_blocked", a_ready_out, 1'b0);
    step();
    #1 chk("after_pop_a_granted", a_ready_out, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    $display("fill sequence done");

    // Flush at count 5 with A requesting in the same cycle.
    do_reset("flush5");
    a_valid_in = 1;
    for (int i = 0; i < 5; i++) begin a_data_in = 8'(8'h50 + i); step(); end
    flush_in = 1;
    #1 chk("flush_no_grant", a_ready_out, 1'b0);
    step();
    idle_inputs();
    nb = 0; nd = 0; nr = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      nb += int'(busy_out); nd += int'(q_dequeue_out); nr += int'(rd_valid_out);
      step();
    end
    chk("flush_busy_cycles", nb, 6);
    chk("flush_dequeues", nd, 5);
    chk("flush_rd_valid", nr, 0);
    $display("flush5: busy %0d cycles, %0d dequeues, %0d reads", nb, nd, nr);
    pop_valid_in = 1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("pop_empty_blocked", pop_ready_out, 1'b0);
      step();
    end
    idle_inputs();

    // Flush of an empty queue occupies FLUSH for exactly one cycle.
    flush_in = 1;
    step();
    flush_in = 0;
    nb = 0;
    for (int k = 0; k < 5; k++) begin #1 nb += int'(busy_out); step(); end
    chk("empty_flush_busy", nb, 1);
    $display("empty flush: busy %0d cycles", nb);

    // Reset while a push is in flight.
    a_valid_in = 1; a_data_in = 8'h77;
    step();
    #1 chk("push_inflight", q_enqueue_out, 1'b1);
    do_reset("midpush");

`ifdef QARB_LEN_CHECK_EN
    a_valid_in = 1;
    step(); step();
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    #1 chk("len_err_clear", len_err_out, 1'b0);
    len_bias = 1;
    step();
    len_bias = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("len_err_sticky", len_err_out, 1'b1);
      step();
    end
    do_reset("lenerr");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      a_valid_in   = ($urandom_range(0, 2) != 0);
      b_valid_in   = ($urandom_range(0, 2) != 0);
      pop_valid_in = ($urandom_range(0, 1) != 0);
      flush_in     = ($urandom_range(0, 39) == 0);
      a_data_in    = 8'($urandom);
      b_data_in    = 8'($urandom);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 12; i++) step();
    $display("random run: %0d cycles", 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
